trng_harvest_fifo: RTL
======================

// Module: trng_harvest_fifo
// PURPOSE
//  Downstream consumer of the ring-oscillator sample bit. Collects one raw bit per sample strobe.
//  Optionally whitens the bits with a von Neumann debiaser, then packs them MSB-first into words.
//  Buffers the words in a small FIFO that the register bank pops on read.
//  Also runs a repetition-count health test on the raw stream.
// PARAMETERS
//  WIDTH       32   packed word width; bit counter is $clog2(WIDTH) bits
//  DEPTH_LOG2  3    FIFO depth = 2**DEPTH_LOG2 words
//  REP_LIMIT   34   consecutive identical raw bits that trip health_fail (2..1023)
// PORTS
//  clk           in   1             system clock
//  rst           in   1             synchronous reset, active-high
//  en            in   1             harvest enable (from enable register)
//  sample_valid  in   1             one-cycle strobe: sample_bit is a new raw bit
//  sample_bit    in   1             raw ring-oscillator bit
//  debias_en     in   1             1 = von Neumann debias, 0 = pass raw bits
//  rd_en         in   1             pop request from register-bank read
//  rd_data       out  WIDTH         FIFO head word (first-word-fall-through)
//  rd_valid      out  1             FIFO not empty
//  level         out  DEPTH_LOG2+1  words held, 0..2**DEPTH_LOG2
//  overflow      out  1             sticky: a completed word was dropped because the FIFO was full
//  health_fail   out  1             sticky: repetition limit reached
//  clr_flags     in   1             one-cycle pulse; clears overflow and health_fail
// BEHAVIOUR
//  Reset:
//   - all outputs 0; FIFO empty; pair FSM in NO_FIRST; bit count 0; repetition count 0.
//  Accept:
//   - a raw bit is accepted when en & sample_valid. Nothing else happens when en=0.
//  Debias FSM (only when debias_en=1), states NO_FIRST and HAVE_FIRST:
//   - NO_FIRST --accept--> HAVE_FIRST; the accepted bit is stored as b0.
//   - HAVE_FIRST --accept(b1)--> NO_FIRST.
//   - If b0 != b1, emit b0 to the packer in the same cycle. If b0 == b1, emit nothing.
//   - When debias_en=0, every accepted bit is emitted and the FSM is held in NO_FIRST.
//  Packer:
//   - Each emitted bit shifts in as shreg <= {shreg[WIDTH-2:0], bit} and cnt increments.
//   - The emit that brings cnt to WIDTH writes {shreg[WIDTH-2:0], bit} to the FIFO on the same edge.
//     cnt then returns to 0.
//   - So the word is readable 1 cycle after the edge that accepted its last bit.
//  en low:
//   - clears the FSM to NO_FIRST and clears cnt to 0. The partial word is discarded.
//   - FIFO contents are kept and can still be read.
//  FIFO:
//   - Circular buffer with wr_ptr and rd_ptr of DEPTH_LOG2 bits that wrap modulo depth.
//   - level is a separate counter.
//   - rd_data shows mem[rd_ptr] when rd_valid=1 and is forced to 0 when the FIFO is empty.
//   - Pop: rd_en & rd_valid advances rd_ptr. rd_en while empty is ignored and changes no state.
//   - Push while full with no pop: word dropped, overflow set to 1, pointers unchanged, packer still restarts at cnt=0.
//   - Push and pop in the same cycle while full: both take effect and level stays at DEPTH.
//   - Push and pop in the same cycle while empty: the pop is ignored and level becomes 1.
//  Health test (runs on raw accepted bits whatever debias_en is):
//   - rep_cnt counts consecutive equal bits.
//   - On an accept: if bit == last_bit, rep_cnt saturates upward; otherwise rep_cnt is set to 1.
//   - The first accept after reset sets rep_cnt to 1.
//   - health_fail is set on the edge where rep_cnt reaches REP_LIMIT.
//   - Harvesting is not blocked by health_fail; software decides what to do.
//  Flag clear:
//   - clr_flags takes priority over a set in the same cycle, so the flag reads 0 afterwards.
//   - clr_flags also sets rep_cnt to 0.
//  Reset mid-operation:
//   - Returns to the reset state on the next edge. In-flight words are lost.
// TESTING
//  - debias_en=0: feed 32 bits 0xDEADBEEF MSB first -> level 0->1 one cycle after the 32nd accept;
//    rd_data=0xDEADBEEF; rd_en pulse -> rd_valid=0, rd_data=0.
//  - debias_en=1: feed pairs 01,10,00,11 repeated 16 times -> 32 emitted bits 0,1,0,1,...;
//    rd_data=0x55555555 after 128 accepts.
//  - Fill 8 words, then push a 9th -> overflow=1, level=8, head word unchanged.
//    Push a 10th with simultaneous rd_en -> level stays 8, data order preserved.
//    clr_flags -> overflow=0.
//  - Feed 34 consecutive 1s with REP_LIMIT=34 -> health_fail rises after the 34th accept and not before.
//    Feed 33 ones then a 0 -> health_fail stays 0.
//  - Feed 20 bits, drop en for 1 cycle, then feed 32 new bits -> the FIFO word equals only the 32 new bits.
//    rd_en while empty -> level stays 0.
//  - Assert rst with 3 words and 5 partial bits held -> next cycle level=0, rd_valid=0, flags=0.
//    A following 32-bit feed packs from bit 0.

Source files
------------

// File: rtl/trng_harvest_fifo.sv
// TRNG harvester: optional von Neumann debias, MSB-first word packing, FWFT word FIFO
// and a repetition-count health test on the raw sample stream.
module trng_harvest_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned REP_LIMIT  = 34
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sample_valid,
  input  logic                  sample_bit,
  input  logic                  debias_en,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  health_fail,
  input  logic                  clr_flags
);

  localparam int unsigned CntW  = $clog2(WIDTH);
  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned LvlW  = DEPTH_LOG2 + 1;
  localparam int unsigned RepW  = 10;

  typedef enum logic {StNoFirst, StHaveFirst} pair_st_e;

  pair_st_e               state_q, state_d;
  logic                   b0_q, b0_d;
  logic [WIDTH-1:0]       shreg_q;
  logic [CntW-1:0]        cnt_q;
  logic [WIDTH-1:0]       mem_q [Depth];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]        level_q;
  logic                   overflow_q, health_fail_q;
  logic [RepW-1:0]        rep_q, rep_d;
  logic                   last_q;

  logic             accept, emit, emit_bit, push, pop, full, wr_ok, rep_hit;
  logic [WIDTH-1:0] word;

  assign accept = en & sample_valid;

  // Pair FSM: next state and debiased emit
  always_comb begin
    state_d  = state_q;
    b0_d     = b0_q;
    emit     = 1'b0;
    emit_bit = sample_bit;
    if (!en || !debias_en) begin
      state_d = StNoFirst;
    end
    if (accept) begin
      if (!debias_en) begin
        emit = 1'b1;
      end else begin
        case (state_q)
          StNoFirst: begin
            state_d = StHaveFirst;
            b0_d    = sample_bit;
          end
          StHaveFirst: begin
            state_d  = StNoFirst;
            emit     = (b0_q != sample_bit);
            emit_bit = b0_q;
          end
          default: state_d = StNoFirst;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StNoFirst;
      b0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
    end
  end

  // Packer: the emit that completes a word writes it straight to the FIFO
  assign word = {shreg_q[WIDTH-2:0], emit_bit};
  assign push = emit && (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (!en) begin
      cnt_q <= '0;
    end else if (emit) begin
      shreg_q <= word;
      cnt_q   <= push ? '0 : cnt_q + CntW'(1);
    end
  end

  // FIFO
  assign full     = (level_q == LvlW'(Depth));
  assign rd_valid = (level_q != '0);
  assign pop      = rd_en & rd_valid;
  // A pop in the same cycle frees the slot a full FIFO needs
  assign wr_ok    = push & (~full | pop);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      case ({wr_ok, pop})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
      if (clr_flags) begin
        overflow_q <= 1'b0;
      end else if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Repetition-count health test on raw accepted bits
  always_comb begin
    rep_d = rep_q;
    if (accept) begin
      if (rep_q == '0 || sample_bit != last_q) begin
        rep_d = RepW'(1);
      end else if (rep_q != RepW'(REP_LIMIT)) begin
        rep_d = rep_q + RepW'(1);
      end
    end
  end

  assign rep_hit     = accept && (rep_d == RepW'(REP_LIMIT));
  assign health_fail = health_fail_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q         <= '0;
      last_q        <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      if (accept) last_q <= sample_bit;
      if (clr_flags) begin
        rep_q         <= '0;
        health_fail_q <= 1'b0;
      end else begin
        rep_q <= rep_d;
        if (rep_hit) health_fail_q <= 1'b1;
      end
    end
  end

endmodule
